data_merge: RTL and testbench
=============================

# data_merge

Receive-side counterpart of the ping-pong data switch. It takes the two AXI-Stream lanes the switch produces and rebuilds the original single payload stream in order. It also strips the per-frame metadata and header trailer beats, checks them for consistency, and reports frame status. It sits downstream of the two parallel processing paths, before the sink.

## Interface
Parameters:
- DW, 128: data width of all streams.
- PP_GROUP, 2: packets per ping-pong group.
- PACKET_SIZE, 2: beats per packet. GROUP = PP_GROUP*PACKET_SIZE beats per lane turn.
- FRAME_SIZE, 256: payload beats per frame, summed over both lanes. Must be a multiple of 2*GROUP.
- META_LENGTH, 3: metadata beats per lane per frame.
- HEADER_LENGTH, 3: header beats per lane per frame.

Ports:
- clk, in, 1: clock.
- resetn, in, 1: reset. Asynchronous, active-low.
- axis_in1_tdata / axis_in1_tvalid / axis_in1_tready: in / in / out, DW / 1 / 1. Lane 1, which carries the first group of each frame.
- axis_in2_tdata / axis_in2_tvalid / axis_in2_tready: in / in / out, DW / 1 / 1. Lane 2.
- axis_out_tdata / axis_out_tvalid / axis_out_tready: out / out / in, DW / 1 / 1. Merged payload.
- axis_out_tlast, out, 1: marks the last payload beat of a frame.
- frame_done, out, 1: one-cycle pulse when a frame's trailer is fully consumed.
- trailer_err, out, 1: sticky flag. Cleared only by reset.
- frame_count, out, 16: completed frames. Wraps modulo 2^16.
- beat_count, out, 16: payload beats accepted in the current frame.

## Operation
- Output stage is a single register holding tdata, tvalid and tlast. It is "free" when it is empty (tvalid=0) or when it is being drained this cycle (axis_out_tready=1).
- States: PAYLOAD and TRAILER. Reset enters PAYLOAD with lane 1 selected.
- PAYLOAD state:
  - The selected lane's tready equals "register free"; the other lane's tready is 0.
  - Each accepted beat loads the output register and increments beat_count and the group counter.
  - When the group counter reaches GROUP-1 on an accepted beat, the group counter returns to 0 and the selected lane toggles.
  - When beat_count reaches FRAME_SIZE-1 on an accepted beat, that beat is loaded with tlast=1 and the state moves to TRAILER.
- TRAILER state:
  - Both lanes' tready equal (axis_in1_tvalid & axis_in2_tvalid). Beats are consumed in lockstep, one pair per cycle, and are not forwarded.
  - The trailer counter counts from 0 to META_LENGTH+HEADER_LENGTH-1.
  - If the two lanes' tdata differ on any pair, trailer_err is set.
  - On the last pair: frame_done pulses, frame_count increments, beat_count, group counter and trailer counter clear, lane 1 is selected, and the state returns to PAYLOAD.
  - Output-register draining continues independently during TRAILER.
- A lane with tvalid=0 while selected stalls the merge. The other lane is never read out of turn.
- All counters are 16-bit. The group and trailer counters compare with == against their parameter-derived limits.

## Timing
- Reset values: axis_out_tvalid, axis_out_tlast, axis_out_tdata, frame_done, trailer_err, frame_count and beat_count are all 0. Both input tready signals are 0 while resetn=0.
- Latency: a beat accepted at edge N is presented on axis_out at N+1.
- Throughput: 1 beat/cycle with axis_out_tready held high, including across lane toggles, with no bubble.
- Lane toggle takes effect on the cycle after the last accepted beat of a group.
- frame_done is asserted for exactly the cycle after the final trailer pair is accepted.
- axis_out_tdata/tlast hold stable while tvalid=1 and tready=0.
- Reset asserted mid-frame clears the state immediately and asynchronously. Any partially merged frame is dropped and the output valid is deasserted.

## Test plan
- Basic ordering (PP_GROUP=2, PACKET_SIZE=2, FRAME_SIZE=16, META=HEADER=3):
  - Stimulus: lane1 sends A0..A7 then 6 trailer beats of 1; lane2 sends B0..B7 then the same trailer.
  - Required: output is A0-A3, B0-B3, A4-A7, B4-B7; tlast only on B7; frame_done once; frame_count=1; trailer_err=0.
- Backpressure:
  - Stimulus: axis_out_tready toggles 1,0,1,0 across the frame.
  - Required: same 16-beat order, no duplicated or lost beat, and data stable while stalled.
- Lane starvation:
  - Stimulus: lane2 tvalid held 0 for 10 cycles at its first turn while lane1 stays valid.
  - Required: lane1 tready stays 0 and no output beat is produced until B0 arrives.
- Trailer mismatch:
  - Stimulus: lane2 sends 1111 instead of 1 on its third trailer beat.
  - Required: trailer_err=1 from the next cycle on, and it stays 1 through the following clean frame.
- Trailer skew:
  - Stimulus: lane1 trailer is presented 3 cycles before lane2's.
  - Required: no trailer beat is consumed until both lanes are valid; frame_done fires after 6 joint acceptances.
- Reset mid-frame:
  - Stimulus: resetn is pulsed low after 5 payload beats.
  - Required: outputs return to 0 asynchronously; the next frame starts on lane 1 with beat_count=0.

Source files
------------

// File: rtl/data_merge_if.sv
// -----------------------------------------------------------------------------
// data_merge_if
// Stream bundle around the data_merge block: two incoming AXI-Stream lanes
// from the ping-pong paths and the single merged outgoing stream.
//
//   axis_in1_*  : lane 1 (first group of each frame), tdata/tvalid/tready
//   axis_in2_*  : lane 2, tdata/tvalid/tready
//   axis_out_*  : merged payload, tdata/tvalid/tready/tlast
//
// Modports:
//   slave  : the merge block (sinks both lanes, sources the merged stream)
//   master : the environment around it (sources lanes, sinks merged stream)
// -----------------------------------------------------------------------------
interface data_merge_if #(
    parameter int DW = 128
);
    logic [DW-1:0] axis_in1_tdata;
    logic          axis_in1_tvalid;
    logic          axis_in1_tready;

    logic [DW-1:0] axis_in2_tdata;
    logic          axis_in2_tvalid;
    logic          axis_in2_tready;

    logic [DW-1:0] axis_out_tdata;
    logic          axis_out_tvalid;
    logic          axis_out_tready;
    logic          axis_out_tlast;

    modport slave (
        input  axis_in1_tdata, axis_in1_tvalid,
        output axis_in1_tready,
        input  axis_in2_tdata, axis_in2_tvalid,
        output axis_in2_tready,
        output axis_out_tdata, axis_out_tvalid, axis_out_tlast,
        input  axis_out_tready
    );

    modport master (
        output axis_in1_tdata, axis_in1_tvalid,
        input  axis_in1_tready,
        output axis_in2_tdata, axis_in2_tvalid,
        input  axis_in2_tready,
        input  axis_out_tdata, axis_out_tvalid, axis_out_tlast,
        output axis_out_tready
    );
endinterface

// File: rtl/data_merge.sv
// -----------------------------------------------------------------------------
// data_merge
// Rebuilds the original payload stream from the two ping-pong lanes. Payload
// is taken GROUP beats at a time, alternating lane 1 / lane 2, starting on
// lane 1 each frame. After FRAME_SIZE payload beats, the per-lane trailer
// (metadata + header beats) is consumed from both lanes in lockstep, compared
// pairwise, and discarded.
//
// Ports:
//   clk, resetn   : clock, asynchronous active-low reset
//   axis          : data_merge_if.slave (lanes in, merged stream out)
//   frame_done    : one-cycle pulse after the last trailer pair is consumed
//   trailer_err   : sticky, set when a trailer pair differs; reset clears it
//   frame_count   : completed frames, wraps at 2^16
//   beat_count    : payload beats accepted in the current frame
// -----------------------------------------------------------------------------
module data_merge #(
    parameter int DW            = 128,
    parameter int PP_GROUP      = 2,
    parameter int PACKET_SIZE   = 2,
    parameter int FRAME_SIZE    = 256,
    parameter int META_LENGTH   = 3,
    parameter int HEADER_LENGTH = 3
) (
    input  logic          clk,
    input  logic          resetn,
    data_merge_if.slave   axis,
    output logic          frame_done,
    output logic          trailer_err,
    output logic [15:0]   frame_count,
    output logic [15:0]   beat_count
);

    localparam int          GROUP      = PP_GROUP * PACKET_SIZE;
    localparam logic [15:0] GROUP_LAST = 16'(GROUP - 1);
    localparam logic [15:0] FRAME_LAST = 16'(FRAME_SIZE - 1);
    localparam logic [15:0] TRL_LAST   = 16'(META_LENGTH + HEADER_LENGTH - 1);

    typedef enum logic [0:0] {
        ST_PAYLOAD = 1'b0,
        ST_TRAILER = 1'b1
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;

    logic          sel_r;          // 1'b0 = lane 1 selected, 1'b1 = lane 2
    logic [15:0]   grp_cnt_r;
    logic [15:0]   beat_cnt_r;
    logic [15:0]   trl_cnt_r;
    logic [15:0]   frame_cnt_r;
    logic          frame_done_r;
    logic          trailer_err_r;

    logic [DW-1:0] out_data_r;
    logic          out_valid_r;
    logic          out_last_r;

    logic          reg_free_s;
    logic          in1_rdy_s;
    logic          in2_rdy_s;
    logic          pay_acc_s;
    logic          trl_acc_s;
    logic [DW-1:0] sel_data_s;
    logic          grp_last_s;
    logic          beat_last_s;
    logic          trl_last_s;

    assign grp_last_s  = (grp_cnt_r  == GROUP_LAST);
    assign beat_last_s = (beat_cnt_r == FRAME_LAST);
    assign trl_last_s  = (trl_cnt_r  == TRL_LAST);

    // Next-state and handshake decode: only the selected lane may be drained
    // during payload; during trailer both lanes move together or not at all.
    always_comb begin
        state_nxt_s = state_r;
        in1_rdy_s   = 1'b0;
        in2_rdy_s   = 1'b0;
        pay_acc_s   = 1'b0;
        trl_acc_s   = 1'b0;
        sel_data_s  = axis.axis_in1_tdata;
        reg_free_s  = (~out_valid_r) | axis.axis_out_tready;

        case (state_r)
            ST_PAYLOAD: begin
                if (sel_r == 1'b0) begin
                    in1_rdy_s  = reg_free_s;
                    pay_acc_s  = reg_free_s & axis.axis_in1_tvalid;
                    sel_data_s = axis.axis_in1_tdata;
                end else begin
                    in2_rdy_s  = reg_free_s;
                    pay_acc_s  = reg_free_s & axis.axis_in2_tvalid;
                    sel_data_s = axis.axis_in2_tdata;
                end
                if (pay_acc_s && beat_last_s) begin
                    state_nxt_s = ST_TRAILER;
                end else begin
                    state_nxt_s = ST_PAYLOAD;
                end
            end
            ST_TRAILER: begin
                trl_acc_s = axis.axis_in1_tvalid & axis.axis_in2_tvalid;
                in1_rdy_s = trl_acc_s;
                in2_rdy_s = trl_acc_s;
                if (trl_acc_s && trl_last_s) begin
                    state_nxt_s = ST_PAYLOAD;
                end else begin
                    state_nxt_s = ST_TRAILER;
                end
            end
            default: begin
                state_nxt_s = ST_PAYLOAD;
            end
        endcase
    end

    // Ready is forced low while reset is held so no upstream beat is lost
    // into a block that is being cleared.
    assign axis.axis_in1_tready = in1_rdy_s & resetn;
    assign axis.axis_in2_tready = in2_rdy_s & resetn;

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_PAYLOAD;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Output register, lane selection, counters and trailer status.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sel_r         <= 1'b0;
            grp_cnt_r     <= 16'd0;
            beat_cnt_r    <= 16'd0;
            trl_cnt_r     <= 16'd0;
            frame_cnt_r   <= 16'd0;
            frame_done_r  <= 1'b0;
            trailer_err_r <= 1'b0;
            out_data_r    <= '0;
            out_valid_r   <= 1'b0;
            out_last_r    <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;

            if (pay_acc_s) begin
                out_data_r  <= sel_data_s;
                out_valid_r <= 1'b1;
                out_last_r  <= beat_last_s;
                beat_cnt_r  <= beat_cnt_r + 16'd1;
                if (grp_last_s) begin
                    grp_cnt_r <= 16'd0;
                    sel_r     <= ~sel_r;
                end else begin
                    grp_cnt_r <= grp_cnt_r + 16'd1;
                end
            end else if (axis.axis_out_tready) begin
                // Drain; data and tlast are left as-is, valid qualifies them.
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end

            if (trl_acc_s) begin
                if (axis.axis_in1_tdata != axis.axis_in2_tdata) begin
                    trailer_err_r <= 1'b1;
                end else begin
                    trailer_err_r <= trailer_err_r;
                end
                if (trl_last_s) begin
                    frame_done_r <= 1'b1;
                    frame_cnt_r  <= frame_cnt_r + 16'd1;
                    beat_cnt_r   <= 16'd0;
                    grp_cnt_r    <= 16'd0;
                    trl_cnt_r    <= 16'd0;
                    sel_r        <= 1'b0;
                end else begin
                    trl_cnt_r <= trl_cnt_r + 16'd1;
                end
            end
        end
    end

    assign axis.axis_out_tdata  = out_data_r;
    assign axis.axis_out_tvalid = out_valid_r;
    assign axis.axis_out_tlast  = out_last_r;
    assign frame_done           = frame_done_r;
    assign trailer_err          = trailer_err_r;
    assign frame_count          = frame_cnt_r;
    assign beat_count           = beat_cnt_r;

endmodule

// File: tb/tb_data_merge.sv
// -----------------------------------------------------------------------------
// tb_data_merge
// Self-checking bench for data_merge with a 16-beat frame, 4-beat groups and
// a 6-beat trailer. A cycle table covers one full frame; scripted frames cover
// backpressure, lane starvation, trailer mismatch, trailer skew and reset.
// -----------------------------------------------------------------------------
module tb_data_merge;

    localparam int DW  = 32;
    localparam int FS  = 16;
    localparam int TRL = 6;

    logic        clk = 1'b0;
    logic        resetn;
    logic        frame_done;
    logic        trailer_err;
    logic [15:0] frame_count;
    logic [15:0] beat_count;

    int checks   = 0;
    int failures = 0;
    int exp_frames = 0;
    logic err_sticky = 1'b0;

    always #5 clk = ~clk;

    data_merge_if #(.DW(DW)) bus ();

    data_merge #(
        .DW(DW), .PP_GROUP(2), .PACKET_SIZE(2), .FRAME_SIZE(FS),
        .META_LENGTH(3), .HEADER_LENGTH(3)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .axis(bus),
        .frame_done(frame_done),
        .trailer_err(trailer_err),
        .frame_count(frame_count),
        .beat_count(beat_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    function automatic logic [31:0] a_beat(input int i);
        return 32'hA000_0000 + 32'(i);
    endfunction

    function automatic logic [31:0] b_beat(input int i);
        return 32'hB000_0000 + 32'(i);
    endfunction

    // Expected merged order: A0-3, B0-3, A4-7, B4-7.
    function automatic logic [31:0] merged(input int i);
        int k;
        k = (i / 8) * 4 + (i % 4);
        return ((i / 4) % 2 == 0) ? a_beat(k) : b_beat(k);
    endfunction

    task automatic drive(input logic v1, input logic [31:0] d1,
                         input logic v2, input logic [31:0] d2, input logic ordy);
        bus.axis_in1_tvalid = v1;
        bus.axis_in1_tdata  = d1;
        bus.axis_in2_tvalid = v2;
        bus.axis_in2_tdata  = d2;
        bus.axis_out_tready = ordy;
    endtask

    typedef struct {
        logic        v1;
        logic [31:0] d1;
        logic        v2;
        logic [31:0] d2;
        logic        ordy;
        logic        e_r1;
        logic        e_r2;
        logic        e_ov;
        logic [31:0] e_od;
        logic        e_ol;
        logic        e_fd;
        logic [15:0] e_bc;
    } vec_t;

    vec_t vt [FS + TRL + 1];

    // One frame with both lanes always offering their next beat.
    // rmode 1 toggles out_tready; starve holds lane2 off for that many cycles
    // at its first turn; skew holds lane2's trailer back that many cycles;
    // bad_idx >= 0 corrupts that lane2 trailer beat.
    task automatic run_frame(input int rmode, input int starve, input int skew,
                             input int bad_idx);
        logic [31:0] q1[$];
        logic [31:0] q2[$];
        logic [31:0] got_d[$];
        logic        got_l[$];
        int cyc = 0, fd_seen = 0, since = 0, joint = 0, t2_wait = 0;
        logic v1, v2, ordy, prev_stall = 1'b0, prev_l = 1'b0, exp_err_next = 1'b0;
        logic [31:0] d1, d2, prev_d = 32'd0;
        for (int i = 0; i < 8; i++) begin
            q1.push_back(a_beat(i));
            q2.push_back(b_beat(i));
        end
        for (int t = 0; t < TRL; t++) begin
            q1.push_back(32'd1);
            q2.push_back((t == bad_idx) ? 32'h0000_1111 : 32'd1);
        end
        chk1("trailer_err_at_start", trailer_err, err_sticky);
        while (since < 2 && cyc < 300) begin
            @(negedge clk);
            v1 = (q1.size() > 0);
            d1 = v1 ? q1[0] : 32'd0;
            v2 = (q2.size() > 0);
            if (starve > 0 && cyc < 4 + starve) v2 = 1'b0;
            if (skew > 0 && q2.size() <= TRL && t2_wait < skew) v2 = 1'b0;
            d2 = (q2.size() > 0) ? q2[0] : 32'd0;
            ordy = (rmode == 1) ? (cyc % 2 == 0) : 1'b1;
            drive(v1, d1, v2, d2, ordy);
            #1;
            if (exp_err_next) begin
                chk1("trailer_err_next_cycle", trailer_err, 1'b1);
                exp_err_next = 1'b0;
            end
            if (starve > 0 && cyc >= 5 && cyc < 4 + starve) begin
                chk1("starve_in1_tready", bus.axis_in1_tready, 1'b0);
                chk1("starve_out_tvalid", bus.axis_out_tvalid, 1'b0);
            end
            if (skew > 0 && q1.size() <= TRL && v1 && !v2) begin
                chk1("skew_in1_tready", bus.axis_in1_tready, 1'b0);
            end
            if (prev_stall) begin
                chk1("stall_tvalid", bus.axis_out_tvalid, 1'b1);
                chk("stall_tdata", bus.axis_out_tdata, prev_d);
                chk1("stall_tlast", bus.axis_out_tlast, prev_l);
            end
            if (frame_done) fd_seen++;
            if (v1 && v2 && bus.axis_in1_tready && bus.axis_in2_tready) begin
                joint++;
                if (d1 != d2) exp_err_next = 1'b1;
            end
            if (v1 && bus.axis_in1_tready) void'(q1.pop_front());
            if (v2 && bus.axis_in2_tready) void'(q2.pop_front());
            if (bus.axis_out_tvalid && ordy) begin
                got_d.push_back(bus.axis_out_tdata);
                got_l.push_back(bus.axis_out_tlast);
            end
            prev_stall = bus.axis_out_tvalid && !ordy;
            prev_d     = bus.axis_out_tdata;
            prev_l     = bus.axis_out_tlast;
            if (q2.size() <= TRL) t2_wait++;
            if (fd_seen > 0) since++;
            cyc++;
        end
        if (bad_idx >= 0) err_sticky = 1'b1;
        exp_frames++;
        chk("frame_done_timeout_or_pulses", 32'(fd_seen), 32'd1);
        chk("joint_trailer_pairs", 32'(joint), 32'(TRL));
        chk("beats_out", 32'(got_d.size()), 32'(FS));
        for (int i = 0; i < got_d.size() && i < FS; i++) begin
            chk($sformatf("order_beat%0d", i), got_d[i], merged(i));
            chk1($sformatf("tlast_beat%0d", i), got_l[i], (i == FS - 1));
        end
        chk("frame_count", 32'(frame_count), 32'(exp_frames));
        chk1("trailer_err_end", trailer_err, err_sticky);
        chk("beat_count_cleared", 32'(beat_count), 32'd0);
    endtask

    initial begin
        int h1, h2, sel;
        logic [31:0] last_d;

        // Build the single-frame cycle table.
        h1 = 0;
        h2 = 0;
        last_d = 32'd0;
        for (int c = 0; c < FS; c++) begin
            sel = (c / 4) % 2;
            vt[c].v1 = 1'b1;  vt[c].d1 = (h1 < 8) ? a_beat(h1) : 32'd1;
            vt[c].v2 = 1'b1;  vt[c].d2 = (h2 < 8) ? b_beat(h2) : 32'd1;
            vt[c].ordy = 1'b1;
            vt[c].e_r1 = (sel == 0);
            vt[c].e_r2 = (sel == 1);
            vt[c].e_ov = (c > 0);
            vt[c].e_od = last_d;
            vt[c].e_ol = 1'b0;
            vt[c].e_fd = 1'b0;
            vt[c].e_bc = 16'(c);
            if (sel == 0) begin last_d = a_beat(h1); h1++; end
            else          begin last_d = b_beat(h2); h2++; end
        end
        for (int c = FS; c < FS + TRL; c++) begin
            vt[c].v1 = 1'b1;  vt[c].d1 = 32'd1;
            vt[c].v2 = 1'b1;  vt[c].d2 = 32'd1;
            vt[c].ordy = 1'b1;
            vt[c].e_r1 = 1'b1;
            vt[c].e_r2 = 1'b1;
            vt[c].e_ov = (c == FS);
            vt[c].e_od = last_d;
            vt[c].e_ol = 1'b1;
            vt[c].e_fd = 1'b0;
            vt[c].e_bc = 16'(FS);
        end
        vt[FS+TRL].v1 = 1'b0;  vt[FS+TRL].d1 = 32'd0;
        vt[FS+TRL].v2 = 1'b0;  vt[FS+TRL].d2 = 32'd0;
        vt[FS+TRL].ordy = 1'b1;
        vt[FS+TRL].e_r1 = 1'b1;
        vt[FS+TRL].e_r2 = 1'b0;
        vt[FS+TRL].e_ov = 1'b0;
        vt[FS+TRL].e_od = 32'd0;
        vt[FS+TRL].e_ol = 1'b0;
        vt[FS+TRL].e_fd = 1'b1;
        vt[FS+TRL].e_bc = 16'd0;

        // Reset state, with both lanes offering data.
        resetn = 1'b0;
        drive(1'b1, 32'h1234_5678, 1'b1, 32'h8765_4321, 1'b1);
        #23;
        chk1("rst_in1_tready", bus.axis_in1_tready, 1'b0);
        chk1("rst_in2_tready", bus.axis_in2_tready, 1'b0);
        chk1("rst_out_tvalid", bus.axis_out_tvalid, 1'b0);
        chk1("rst_out_tlast", bus.axis_out_tlast, 1'b0);
        chk("rst_out_tdata", bus.axis_out_tdata, 32'd0);
        chk1("rst_frame_done", frame_done, 1'b0);
        chk1("rst_trailer_err", trailer_err, 1'b0);
        chk("rst_frame_count", 32'(frame_count), 32'd0);
        chk("rst_beat_count", 32'(beat_count), 32'd0);
        @(negedge clk);
        drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        resetn = 1'b1;

        // Basic ordering, cycle by cycle.
        for (int r = 0; r < FS + TRL + 1; r++) begin
            @(negedge clk);
            drive(vt[r].v1, vt[r].d1, vt[r].v2, vt[r].d2, vt[r].ordy);
            #1;
            chk1($sformatf("tbl%0d_in1_tready", r), bus.axis_in1_tready, vt[r].e_r1);
            chk1($sformatf("tbl%0d_in2_tready", r), bus.axis_in2_tready, vt[r].e_r2);
            chk1($sformatf("tbl%0d_out_tvalid", r), bus.axis_out_tvalid, vt[r].e_ov);
            if (vt[r].e_ov) begin
                chk($sformatf("tbl%0d_out_tdata", r), bus.axis_out_tdata, vt[r].e_od);
                chk1($sformatf("tbl%0d_out_tlast", r), bus.axis_out_tlast, vt[r].e_ol);
            end
            chk1($sformatf("tbl%0d_frame_done", r), frame_done, vt[r].e_fd);
            chk($sformatf("tbl%0d_beat_count", r), 32'(beat_count), 32'(vt[r].e_bc));
        end
        exp_frames = 1;
        chk("tbl_frame_count", 32'(frame_count), 32'd1);
        chk1("tbl_trailer_err", trailer_err, 1'b0);

        run_frame(1, 0, 0, -1);    // backpressure
        run_frame(0, 10, 0, -1);   // lane2 starvation
        run_frame(0, 0, 0, 2);     // trailer mismatch
        run_frame(0, 0, 0, -1);    // clean frame, error stays sticky
        run_frame(1, 0, 3, -1);    // trailer skew

        // Reset mid-frame after 5 payload beats.
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            drive(1'b1, a_beat(c), (c == 4), b_beat(0), 1'b1);
        end
        @(negedge clk);
        drive(1'b1, a_beat(4), 1'b1, b_beat(1), 1'b0);
        #1;
        chk("mid_beat_count", 32'(beat_count), 32'd5);
        chk1("mid_out_tvalid", bus.axis_out_tvalid, 1'b1);
        #1;
        resetn = 1'b0;
        #1;
        chk1("async_rst_out_tvalid", bus.axis_out_tvalid, 1'b0);
        chk("async_rst_out_tdata", bus.axis_out_tdata, 32'd0);
        chk("async_rst_beat_count", 32'(beat_count), 32'd0);
        chk("async_rst_frame_count", 32'(frame_count), 32'd0);
        chk1("async_rst_trailer_err", trailer_err, 1'b0);
        chk1("async_rst_in1_tready", bus.axis_in1_tready, 1'b0);
        chk1("async_rst_in2_tready", bus.axis_in2_tready, 1'b0);
        @(negedge clk);
        drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        resetn = 1'b1;
        exp_frames = 0;
        err_sticky = 1'b0;
        run_frame(0, 0, 0, -1);    // restarts on lane 1 from A0

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
